// File: rtl/gemm_pkg.sv
// Shared definitions for the GEMM tile-loop controller.
//   gemm_ctrl_state_e : controller FSM states
//   ceil_div          : integer ceiling division used for tile counts
package gemm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_WB    = 3'd4,
        ST_DONE  = 3'd5
    } gemm_ctrl_state_e;

    // Returns ceil(num/den); a zero divisor yields zero rather than X.
    function automatic logic [31:0] ceil_div(input logic [31:0] num, input logic [31:0] den);
        logic [31:0] res;
        res = 32'd0;
        if (den != 32'd0) begin
            res = (num + den - 32'd1) / den;
        end
        return res;
    endfunction

endpackage

// File: rtl/gemm_tile_counter.sv
// Generic nested three-level wrap counter (inner / mid / outer).
//   clk_i, rst_i      : clock, synchronous active-high reset
//   clr_i             : clear all three levels to 0
//   inner_en_i        : advance the inner level (wraps to 0 after its limit-1)
//   step_en_i         : advance the mid level; a mid wrap advances the outer level
//   *_lim_i           : per-level counts (must be >= 1 while counting)
//   inner/mid/outer_o : current counter values
//   *_last_o          : level currently holds limit-1
module gemm_tile_counter #(
    parameter int Width = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inner_en_i,
    input  logic             step_en_i,
    input  logic [Width-1:0] inner_lim_i,
    input  logic [Width-1:0] mid_lim_i,
    input  logic [Width-1:0] outer_lim_i,
    output logic [Width-1:0] inner_o,
    output logic [Width-1:0] mid_o,
    output logic [Width-1:0] outer_o,
    output logic             inner_last_o,
    output logic             mid_last_o,
    output logic             outer_last_o
);

    logic [Width-1:0] inner_q, inner_d;
    logic [Width-1:0] mid_q,   mid_d;
    logic [Width-1:0] outer_q, outer_d;

    assign inner_last_o = (inner_q == inner_lim_i - Width'(1));
    assign mid_last_o   = (mid_q   == mid_lim_i   - Width'(1));
    assign outer_last_o = (outer_q == outer_lim_i - Width'(1));

    assign inner_o = inner_q;
    assign mid_o   = mid_q;
    assign outer_o = outer_q;

    // The inner level and the mid/outer pair have independent enables so the
    // caller can keep mid/outer stable while the inner level wraps.
    always_comb begin
        inner_d = inner_q;
        mid_d   = mid_q;
        outer_d = outer_q;
        if (clr_i) begin
            inner_d = '0;
            mid_d   = '0;
            outer_d = '0;
        end else begin
            if (inner_en_i) begin
                inner_d = inner_last_o ? '0 : inner_q + Width'(1);
            end
            if (step_en_i) begin
                if (mid_last_o) begin
                    mid_d   = '0;
                    outer_d = outer_last_o ? '0 : outer_q + Width'(1);
                end else begin
                    mid_d = mid_q + Width'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inner_q <= '0;
            mid_q   <= '0;
            outer_q <= '0;
        end else begin
            inner_q <= inner_d;
            mid_q   <= mid_d;
            outer_q <= outer_d;
        end
    end

endmodule

// File: rtl/gemm_tile_ctrl.sv
// Output-stationary tile-loop controller for the GEMM accelerator.
// Walks mt (outer), nt, kt (inner) over ragged runtime sizes and drives:
//   sram_a/b_addr_o : A/B tile-word addresses while in RUN
//   sram_c_addr_o, sram_c_we_o : C tile write-back in WB
//   mac_valid_o, acc_clear_o, k_mask_o : registered one cycle after issue
//   row_mask_o, col_mask_o : valid lanes on MAC beats and write-back, else 0
//   busy_o, done_o, err_o  : status (err_o pulses with done_o on a zero size)
// Inputs: clk_i, rst_i (sync, active-high), start_i, M/K/N_size_i, stall_i.
module gemm_tile_ctrl #(
    parameter int M             = 4,
    parameter int K             = 4,
    parameter int N             = 4,
    parameter int SizeAddrWidth = 8,
    parameter int AddrWidth     = 10
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [SizeAddrWidth-1:0] M_size_i,
    input  logic [SizeAddrWidth-1:0] K_size_i,
    input  logic [SizeAddrWidth-1:0] N_size_i,
    input  logic                     stall_i,
    output logic [AddrWidth-1:0]     sram_a_addr_o,
    output logic [AddrWidth-1:0]     sram_b_addr_o,
    output logic [AddrWidth-1:0]     sram_c_addr_o,
    output logic                     sram_c_we_o,
    output logic                     mac_valid_o,
    output logic                     acc_clear_o,
    output logic [M-1:0]             row_mask_o,
    output logic [N-1:0]             col_mask_o,
    output logic [K-1:0]             k_mask_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o
);
    import gemm_pkg::*;

    localparam int CW = SizeAddrWidth + 1;

    gemm_ctrl_state_e         state_q;
    logic                     err_q;
    logic                     mac_valid_q;
    logic                     acc_clear_q;
    logic [K-1:0]             k_mask_q;
    logic [SizeAddrWidth-1:0] m_size_q, k_size_q, n_size_q;
    logic [CW-1:0]            mt_lim_q, kt_lim_q, nt_lim_q;

    logic [CW-1:0]            mt, nt, kt;
    logic                     mt_last, nt_last, kt_last;
    logic                     issue;
    logic                     size_zero;
    logic                     mask_en;
    logic [M-1:0]             row_mask;
    logic [N-1:0]             col_mask;
    logic [K-1:0]             k_mask_d;
    logic [CW-1:0]            a_lin, b_lin, c_lin;

    assign issue     = (state_q == ST_RUN) && !stall_i;
    assign size_zero = (m_size_q == '0) || (k_size_q == '0) || (n_size_q == '0);

    gemm_tile_counter #(
        .Width(CW)
    ) u_cnt (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (state_q == ST_SETUP),
        .inner_en_i  (issue),
        .step_en_i   (state_q == ST_WB),
        .inner_lim_i (kt_lim_q),
        .mid_lim_i   (nt_lim_q),
        .outer_lim_i (mt_lim_q),
        .inner_o     (kt),
        .mid_o       (nt),
        .outer_o     (mt),
        .inner_last_o(kt_last),
        .mid_last_o  (nt_last),
        .outer_last_o(mt_last)
    );

    // Lane is inside the matrix when tile*dim + lane < size.
    function automatic logic lane_ok(input logic [CW-1:0] tile, input int dim, input int lane,
                                     input logic [SizeAddrWidth-1:0] size);
        return (int'(tile) * dim + lane) < int'(size);
    endfunction

    always_comb begin
        row_mask = '0;
        col_mask = '0;
        k_mask_d = '0;
        for (int i = 0; i < M; i++) row_mask[i] = lane_ok(mt, M, i, m_size_q);
        for (int j = 0; j < N; j++) col_mask[j] = lane_ok(nt, N, j, n_size_q);
        for (int l = 0; l < K; l++) k_mask_d[l] = lane_ok(kt, K, l, k_size_q);
    end

    // Tile-major addresses at CW bits; the port keeps the low AddrWidth bits.
    assign a_lin = mt * kt_lim_q + kt;
    assign b_lin = kt * nt_lim_q + nt;
    assign c_lin = mt * nt_lim_q + nt;

    // Sizes and tile counts are plain data: no reset needed.
    always_ff @(posedge clk_i) begin
        if (state_q == ST_IDLE && start_i) begin
            m_size_q <= M_size_i;
            k_size_q <= K_size_i;
            n_size_q <= N_size_i;
        end
        if (state_q == ST_SETUP) begin
            mt_lim_q <= CW'(ceil_div(32'(m_size_q), 32'(M)));
            kt_lim_q <= CW'(ceil_div(32'(k_size_q), 32'(K)));
            nt_lim_q <= CW'(ceil_div(32'(n_size_q), 32'(N)));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            err_q       <= 1'b0;
            mac_valid_q <= 1'b0;
            acc_clear_q <= 1'b0;
            k_mask_q    <= '0;
        end else begin
            // SRAM read latency is one cycle, so MAC strobes trail the issue.
            mac_valid_q <= issue;
            acc_clear_q <= issue && (kt == '0);
            k_mask_q    <= issue ? k_mask_d : '0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) state_q <= ST_SETUP;
                end
                ST_SETUP: begin
                    if (size_zero) begin
                        state_q <= ST_DONE;
                        err_q   <= 1'b1;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (issue && kt_last) state_q <= ST_DRAIN;
                end
                ST_DRAIN: state_q <= ST_WB;
                ST_WB: begin
                    state_q <= (nt_last && mt_last) ? ST_DONE : ST_RUN;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    err_q   <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mask_en       = mac_valid_q || (state_q == ST_WB);
    assign row_mask_o    = mask_en ? row_mask : '0;
    assign col_mask_o    = mask_en ? col_mask : '0;
    assign k_mask_o      = k_mask_q;
    assign mac_valid_o   = mac_valid_q;
    assign acc_clear_o   = acc_clear_q;
    assign sram_a_addr_o = (state_q == ST_RUN) ? AddrWidth'(a_lin) : '0;
    assign sram_b_addr_o = (state_q == ST_RUN) ? AddrWidth'(b_lin) : '0;
    assign sram_c_addr_o = (state_q == ST_WB)  ? AddrWidth'(c_lin) : '0;
    assign sram_c_we_o   = (state_q == ST_WB);
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = (state_q == ST_DONE);
    assign err_o         = err_q;

endmodule

// File: tb/tb_gemm_tile_ctrl.sv
module tb_gemm_tile_ctrl;
    import gemm_pkg::*;

    localparam int M    = 4;
    localparam int K    = 4;
    localparam int N    = 4;
    localparam int SW   = 8;
    localparam int AW   = 10;
    localparam int MAXC = 4096;

    logic          clk = 1'b0;
    logic          rst_i, start_i, stall_i;
    logic [SW-1:0] M_size_i, K_size_i, N_size_i;
    logic [AW-1:0] sram_a_addr_o, sram_b_addr_o, sram_c_addr_o;
    logic          sram_c_we_o, mac_valid_o, acc_clear_o, busy_o, done_o, err_o;
    logic [M-1:0]  row_mask_o;
    logic [N-1:0]  col_mask_o;
    logic [K-1:0]  k_mask_o;

    always #5 clk = ~clk;

    gemm_tile_ctrl #(.M(M), .K(K), .N(N), .SizeAddrWidth(SW), .AddrWidth(AW)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .M_size_i(M_size_i), .K_size_i(K_size_i), .N_size_i(N_size_i),
        .stall_i(stall_i),
        .sram_a_addr_o(sram_a_addr_o), .sram_b_addr_o(sram_b_addr_o),
        .sram_c_addr_o(sram_c_addr_o), .sram_c_we_o(sram_c_we_o),
        .mac_valid_o(mac_valid_o), .acc_clear_o(acc_clear_o),
        .row_mask_o(row_mask_o), .col_mask_o(col_mask_o), .k_mask_o(k_mask_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    int n_pass = 0;
    int n_chk  = 0;

    // Expected per-cycle trace (cycle 0 = start cycle)
    bit            stall_at [MAXC];
    bit            e_busy [MAXC], e_valid [MAXC], e_clr [MAXC], e_we [MAXC];
    bit            e_done [MAXC], e_err [MAXC], e_run [MAXC];
    logic [K-1:0]  e_k   [MAXC];
    logic [M-1:0]  e_row [MAXC];
    logic [N-1:0]  e_col [MAXC];
    logic [AW-1:0] e_a [MAXC], e_b [MAXC], e_c [MAXC];
    int            e_dcyc;

    // Captured DUT values per cycle
    logic [AW-1:0] c_a [MAXC], c_b [MAXC], c_c [MAXC];
    logic [K-1:0]  c_k [MAXC];
    logic [M-1:0]  c_row [MAXC];
    logic [N-1:0]  c_col [MAXC];
    logic          c_clr [MAXC];

    typedef struct {
        int msz, ksz, nsz;
        int st_start, st_len;
        int exp_done, exp_beats;
        bit exp_err;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] pack(input logic busy, valid, clr, we, done, err,
                                         input logic [M-1:0] row, input logic [N-1:0] col,
                                         input logic [K-1:0] k,
                                         input logic [AW-1:0] a, b, cc);
        return {16'd0, busy, valid, clr, we, done, err, row, col, k, a, b, cc};
    endfunction

    function automatic logic [M-1:0] rowm(input int mt, input int sz);
        logic [M-1:0] r;
        for (int i = 0; i < M; i++) r[i] = (mt * M + i < sz);
        return r;
    endfunction
    function automatic logic [N-1:0] colm(input int nt, input int sz);
        logic [N-1:0] r;
        for (int j = 0; j < N; j++) r[j] = (nt * N + j < sz);
        return r;
    endfunction
    function automatic logic [K-1:0] km(input int kt, input int sz);
        logic [K-1:0] r;
        for (int l = 0; l < K; l++) r[l] = (kt * K + l < sz);
        return r;
    endfunction

    // Schedule from the timing rules: each k-issue waits for a non-stalled
    // cycle, its MAC beat follows one cycle later, then one drain cycle and
    // one write-back cycle; done follows the last write-back.
    task automatic build_model(input int msz, input int ksz, input int nsz);
        int mtn, ktn, ntn, c;
        for (int i = 0; i < MAXC; i++) begin
            e_busy[i] = 0; e_valid[i] = 0; e_clr[i] = 0; e_we[i] = 0;
            e_done[i] = 0; e_err[i] = 0; e_run[i] = 0;
            e_k[i] = '0; e_row[i] = '0; e_col[i] = '0;
            e_a[i] = '0; e_b[i] = '0; e_c[i] = '0;
        end
        if (msz == 0 || ksz == 0 || nsz == 0) begin
            e_busy[1] = 1; e_busy[2] = 1; e_done[2] = 1; e_err[2] = 1;
            e_dcyc = 2;
            return;
        end
        mtn = int'(ceil_div(32'(msz), 32'(M)));
        ktn = int'(ceil_div(32'(ksz), 32'(K)));
        ntn = int'(ceil_div(32'(nsz), 32'(N)));
        c = 2;
        for (int mt = 0; mt < mtn; mt++) begin
            for (int nt = 0; nt < ntn; nt++) begin
                for (int kt = 0; kt < ktn; kt++) begin
                    while (stall_at[c] && c < MAXC - 8) begin
                        e_run[c] = 1; e_a[c] = AW'(mt * ktn + kt); e_b[c] = AW'(kt * ntn + nt);
                        c++;
                    end
                    e_run[c] = 1; e_a[c] = AW'(mt * ktn + kt); e_b[c] = AW'(kt * ntn + nt);
                    e_valid[c+1] = 1; e_clr[c+1] = (kt == 0); e_k[c+1] = km(kt, ksz);
                    e_row[c+1] = rowm(mt, msz); e_col[c+1] = colm(nt, nsz);
                    c++;
                end
                e_we[c+1] = 1; e_c[c+1] = AW'(mt * ntn + nt);
                e_row[c+1] = rowm(mt, msz); e_col[c+1] = colm(nt, nsz);
                c += 2;
            end
        end
        e_dcyc = c;
        e_done[c] = 1;
        for (int i = 1; i <= c; i++) e_busy[i] = 1;
    endtask

    task automatic run_case(input string tag, input int msz, input int ksz, input int nsz,
                            input bit stray, output int got_done, output int got_beats,
                            output logic got_err);
        logic [63:0] act, exp;
        build_model(msz, ksz, nsz);
        got_done = -1; got_beats = 0; got_err = 1'bx;
        for (int c = 0; c <= e_dcyc + 3; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                start_i = 1'b1;
                M_size_i = SW'(msz); K_size_i = SW'(ksz); N_size_i = SW'(nsz);
            end else begin
                start_i = stray && (c < e_dcyc) && ($urandom_range(0, 3) == 0);
                M_size_i = SW'($urandom); K_size_i = SW'($urandom); N_size_i = SW'($urandom);
            end
            stall_i = stall_at[c];
            @(negedge clk);
            c_a[c] = sram_a_addr_o; c_b[c] = sram_b_addr_o; c_c[c] = sram_c_addr_o;
            c_k[c] = k_mask_o; c_row[c] = row_mask_o; c_col[c] = col_mask_o; c_clr[c] = acc_clear_o;
            if (mac_valid_o) got_beats++;
            if (done_o && got_done < 0) begin got_done = c; got_err = err_o; end
            act = pack(busy_o, mac_valid_o, acc_clear_o, sram_c_we_o, done_o, err_o,
                       row_mask_o, col_mask_o, e_valid[c] ? k_mask_o : '0,
                       e_run[c] ? sram_a_addr_o : '0, e_run[c] ? sram_b_addr_o : '0,
                       e_we[c] ? sram_c_addr_o : '0);
            exp = pack(e_busy[c], e_valid[c], e_clr[c], e_we[c], e_done[c], e_err[c],
                       e_row[c], e_col[c], e_k[c], e_a[c], e_b[c], e_c[c]);
            check($sformatf("%s cyc%0d", tag, c), act, exp);
        end
        start_i = 1'b0;
        stall_i = 1'b0;
    endtask

    logic [63:0] all_out;
    assign all_out = pack(busy_o, mac_valid_o, acc_clear_o, sram_c_we_o, done_o, err_o,
                          row_mask_o, col_mask_o, k_mask_o,
                          sram_a_addr_o, sram_b_addr_o, sram_c_addr_o);

    initial begin
        int gd, gb;
        logic ge;
        int ms, ks, ns;

        tbl[0] = '{8, 8, 8, 0, 0, 18, 8, 1'b0};
        tbl[1] = '{5, 4, 6, 0, 0, 14, 4, 1'b0};
        tbl[2] = '{4, 6, 4, 0, 0, 6, 2, 1'b0};
        tbl[3] = '{8, 8, 8, 3, 3, 21, 8, 1'b0};
        tbl[4] = '{8, 8, 0, 0, 0, 2, 0, 1'b1};
        tbl[5] = '{1, 1, 1, 0, 0, 5, 1, 1'b0};
        tbl[6] = '{0, 3, 3, 0, 0, 2, 0, 1'b1};
        tbl[7] = '{9, 13, 7, 0, 0, 38, 24, 1'b0};

        rst_i = 1'b1; start_i = 1'b0; stall_i = 1'b0;
        M_size_i = '0; K_size_i = '0; N_size_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", all_out, 64'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;

        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < MAXC; i++) stall_at[i] = 0;
            for (int i = 0; i < tbl[v].st_len; i++) stall_at[tbl[v].st_start + i] = 1;
            run_case($sformatf("tbl%0d", v), tbl[v].msz, tbl[v].ksz, tbl[v].nsz, 1'b0, gd, gb, ge);
            check($sformatf("tbl%0d_done_cycle", v), 64'(gd), 64'(tbl[v].exp_done));
            check($sformatf("tbl%0d_beats", v), 64'(gb), 64'(tbl[v].exp_beats));
            check($sformatf("tbl%0d_err", v), 64'(ge), 64'(tbl[v].exp_err));
            if (v == 0) begin
                check("t10_a_k0", 64'(c_a[10]), 64'd2);
                check("t10_a_k1", 64'(c_a[11]), 64'd3);
                check("t10_b_k0", 64'(c_b[10]), 64'd0);
                check("t10_b_k1", 64'(c_b[11]), 64'd2);
                check("wb_c_5_9_13_17", {c_c[5], c_c[9], c_c[13], c_c[17]},
                      {AW'(0), AW'(1), AW'(2), AW'(3)});
            end
            if (v == 1) begin
                check("rag_row", 64'(c_row[12]), 64'b0001);
                check("rag_col", 64'(c_col[12]), 64'b0011);
                check("rag_k", 64'(c_k[12]), 64'b1111);
                check("rag_caddr", 64'(c_c[13]), 64'd3);
            end
            if (v == 2) begin
                check("k6_clr_beat0", 64'(c_clr[3]), 64'd1);
                check("k6_clr_beat1", 64'(c_clr[4]), 64'd0);
                check("k6_kmask_beat1", 64'(c_k[4]), 64'b0011);
            end
            if (v == 3) begin
                check("stall_a_frozen", {c_a[3], c_a[4], c_a[5]}, {AW'(1), AW'(1), AW'(1)});
                check("stall_b_frozen", {c_b[3], c_b[4], c_b[5]}, {AW'(2), AW'(2), AW'(2)});
            end
        end

        // Reset during the write-back of tile 1 (cycle 9), then a clean rerun.
        for (int c = 0; c <= 14; c++) begin
            @(posedge clk); #1;
            start_i = (c == 0);
            M_size_i = 8'd8; K_size_i = 8'd8; N_size_i = 8'd8;
            stall_i = 1'b0;
            rst_i = (c == 9);
            @(negedge clk);
            if (c == 9) check("pre_rst_wb", {sram_c_we_o, sram_c_addr_o}, {1'b1, AW'(1)});
            if (c >= 10) check($sformatf("rst_mid cyc%0d", c), all_out, 64'd0);
        end
        for (int i = 0; i < MAXC; i++) stall_at[i] = 0;
        run_case("after_rst", 8, 8, 8, 1'b0, gd, gb, ge);
        check("after_rst_done_cycle", 64'(gd), 64'd18);

        // Randomised sizes, stalls and stray start pulses against the model.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < MAXC; i++) stall_at[i] = ($urandom_range(0, 3) == 0);
            ms = $urandom_range(0, 20);
            ks = $urandom_range(0, 20);
            ns = $urandom_range(0, 20);
            run_case($sformatf("rnd%0d_%0dx%0dx%0d", r, ms, ks, ns), ms, ks, ns, 1'b1, gd, gb, ge);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gemm_tile_ctrl.md
# gemm_tile_ctrl

Parametrised tile-loop controller for the GEMM accelerator: it sequences an output-stationary M×K×N tiled matrix multiply over arbitrary runtime sizes, including sizes that are not multiples of the tile dimensions. It generates SRAM A/B/C word addresses, MAC-valid and accumulator-clear strobes, per-lane edge masks for ragged tiles, the C write-enable, and the done/error status. It sits inside `gemm_accelerator_top` between the three single-port memories and the MAC array. It replaces the fixed-multiple controller and adds ragged-edge masking, stall handling and size checking.

## Interface
- `M`, default 4: tile rows; MAC array height
- `K`, default 4: tile reduction depth
- `N`, default 4: tile columns; MAC array width
- `SizeAddrWidth`, default 8: width of the runtime size inputs
- `AddrWidth`, default 10: SRAM word-address width

- `clk_i`  in  1  sole clock; all logic on rising edge
- `rst_i`  in  1  synchronous, active-high reset
- `start_i`  in  1  start pulse; sampled only in IDLE
- `M_size_i` / `K_size_i` / `N_size_i`  in  SizeAddrWidth  matrix dimensions in elements; latched on accepted start
- `stall_i`  in  1  freeze address issue (RUN only)
- `sram_a_addr_o` / `sram_b_addr_o` / `sram_c_addr_o`  out  AddrWidth  tile-word addresses
- `sram_c_we_o`  out  1  C tile write strobe
- `mac_valid_o`  out  1  A/B read data valid this cycle; MAC must fire
- `acc_clear_o`  out  1  with `mac_valid_o`: load product, do not add
- `row_mask_o`  out  M  valid output rows of the current tile
- `col_mask_o`  out  N  valid output columns of the current tile
- `k_mask_o`  out  K  valid reduction lanes of the current k-tile
- `busy_o`  out  1  high from SETUP through DONE
- `done_o`  out  1  one-cycle completion pulse
- `err_o`  out  1  one-cycle pulse with `done_o` when any size is 0

## Operation
- States: IDLE → SETUP → RUN → DRAIN → WB → (RUN | DONE) → IDLE.
- IDLE: `start_i`=1 latches the sizes and moves to SETUP. `start_i` in any other state is ignored.
- SETUP (1 cycle): compute the tile counts MT=ceil(M_size/M), KT=ceil(K_size/K), NT=ceil(N_size/N) and clear the counters mt, nt, kt.
  - Any size equal to 0: go to DONE with `err_o`=1. No memory access occurs.
- Loop order: mt outermost, then nt, then kt innermost.
- Tile-major addressing:
  - A address = mt*KT + kt
  - B address = kt*NT + nt
  - C address = mt*NT + nt
- RUN: each non-stalled cycle issues the A/B addresses for (mt, nt, kt) and increments kt.
  - Issuing kt=KT-1 moves to DRAIN.
  - With `stall_i`=1 the addresses and counters hold and nothing is issued.
- `mac_valid_o`, `acc_clear_o` and `k_mask_o` are registered copies of the issue cycle (SRAM read latency is 1).
  - `acc_clear_o`=1 only on the beat for kt=0.
- DRAIN: the last MAC beat of the tile; `stall_i` is ignored.
- WB: `sram_c_we_o`=1 with `sram_c_addr_o` = mt*NT + nt. Then:
  - Advance nt; on nt wrap to 0, advance mt.
  - If both wrap, go to DONE; otherwise return to RUN with kt=0.
- DONE: `done_o`=1 for one cycle, then IDLE.
- Masks:
  - `row_mask_o[i]` = (mt*M+i < M_size)
  - `col_mask_o[j]` = (nt*N+j < N_size)
  - `k_mask_o[l]` = (kt*K+l < K_size)
  - Row/col masks are valid on every `mac_valid_o` and `sram_c_we_o` cycle and are 0 otherwise.
- Arithmetic: tile counts and products are computed at SizeAddrWidth+1 bits. The address is the low AddrWidth bits; overflow is the caller's responsibility.
- Reset, including mid-operation: next state IDLE, counters 0. Every output reads 0 after the edge, and no `done_o` is produced.

## Timing
- Reset values: all outputs are 0.
- `start_i` in cycle 0: SETUP in cycle 1; first address in cycle 2.
- Per tile with no stall, KT+2 cycles:
  - addresses in cycles s..s+KT-1
  - MAC beats in cycles s+1..s+KT
  - WB in cycle s+KT+1
- Total: last WB in cycle 1+MT*NT*(KT+2); `done_o` in the cycle after it.
- Each stall cycle in RUN adds exactly one cycle and creates no `mac_valid_o` gap other than the stalled beat.
- Zero size: `done_o` and `err_o` in cycle 2.

## Structure
- Shared package `gemm_pkg`: the state enum `gemm_ctrl_state_e` and a `ceil_div` function. These are reused by the top-level and by the tb golden model.
- Sub-module `gemm_tile_counter`: a generic nested three-level wrap counter (limits, enable, last flags).
- FSM, address multiply and mask generation stay in `gemm_tile_ctrl`.

## Test plan
- Sizes 8/8/8, tile 4, no stall:
  - MT=KT=NT=2
  - WB in cycles 5, 9, 13, 17 at C addresses 0, 1, 2, 3
  - `done_o` in cycle 18
  - tile (1,0) A addresses 2, 3; B addresses 0, 2
- Ragged sizes M=5, K=4, N=6:
  - tile (1,1): `row_mask_o`=0001, `col_mask_o`=0011, `k_mask_o`=1111
  - C address 3
- K_size=6: kt=1 beat has `k_mask_o`=0011; `acc_clear_o` is high only on the kt=0 beat of each tile.
- `stall_i` held 3 cycles mid-RUN:
  - addresses frozen for 3 cycles
  - `done_o` delayed by exactly 3 cycles
  - MAC beat count unchanged
- N_size=0: no address strobes and no `sram_c_we_o`; `done_o`=`err_o`=1 in cycle 2.
- `rst_i` asserted during WB of tile 1:
  - outputs 0 next cycle, no `done_o`
  - a fresh `start_i` reruns from tile (0,0) with correct timing
